// File: rtl/stream_fanout_fork.sv
// One-entry buffered eager fork: one ready/valid stream broadcast to NUM_OUT branches.
// Latency: 1 cycle from acceptance to out_valid; 1 token/cycle when all enabled branches are ready.
// Backpressure: upstream is held until every enabled branch has taken the current token.
//
// Ports:
//   clk        clock
//   flush      synchronous active-high reset; discards any in-flight token
//   cfg_en     static per-branch enable (changed only while flush=1)
//   in_data    upstream token (bit DATA_W-1 is the control/stop flag)
//   in_valid   upstream valid
//   in_ready   upstream ready (combinational from out_ready, never from in_valid)
//   out_data   broadcast token shared by all branches
//   out_valid  per-branch valid
//   out_ready  per-branch ready
//   stall_cnt  saturating count of cycles a held token could not complete
//
// Optional feature: define FANOUT_STALL_CNT_EN to build the stall counter;
// otherwise stall_cnt is tied to zero and no counter flops exist.
module stream_fanout_fork #(
    parameter int NUM_OUT = 6,
    parameter int DATA_W  = 17
) (
    input  logic               clk,
    input  logic               flush,
    input  logic [NUM_OUT-1:0] cfg_en,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [15:0]        stall_cnt
);

    // Holding register and per-branch delivery tracking.
    logic [DATA_W-1:0]  hold_data_q, hold_data_d;
    logic               hold_vld_q,  hold_vld_d;
    logic [NUM_OUT-1:0] sent_q,      sent_d;

    logic [NUM_OUT-1:0] fire;
    logic               done;
    logic               load;

    assign out_data  = hold_data_q;
    assign out_valid = {NUM_OUT{hold_vld_q}} & cfg_en & ~sent_q;
    assign fire      = out_valid & out_ready;

    // A branch no longer blocks the token if it is disabled, has already
    // taken it, or takes it this cycle.
    assign done      = hold_vld_q & (&(~cfg_en | sent_q | out_ready));

    assign in_ready  = ~hold_vld_q | done;
    assign load      = in_valid & in_ready;

    always_comb begin
        hold_data_d = hold_data_q;
        hold_vld_d  = hold_vld_q;
        sent_d      = sent_q;
        if (load) begin
            // Also covers completion of the old token on the same edge.
            hold_data_d = in_data;
            hold_vld_d  = 1'b1;
            sent_d      = '0;
        end else if (done) begin
            hold_vld_d  = 1'b0;
            sent_d      = '0;
        end else begin
            sent_d      = sent_q | fire;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            hold_data_q <= '0;
            hold_vld_q  <= 1'b0;
            sent_q      <= '0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_vld_q  <= hold_vld_d;
            sent_q      <= sent_d;
        end
    end

`ifdef FANOUT_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stalled;

    // A held token that cannot complete means some enabled branch withholds ready.
    assign stalled = hold_vld_q & ~done;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stalled && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_fanout_fork.sv
module tb_stream_fanout_fork;

    localparam int N = 6;
    localparam int W = 17;

    logic         clk = 1'b0;
    logic         flush;
    logic [N-1:0] cfg_en;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic [N-1:0] out_valid;
    logic [N-1:0] out_ready;
    logic [15:0]  stall_cnt;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    stream_fanout_fork #(.NUM_OUT(N), .DATA_W(W)) dut (
        .clk       (clk),
        .flush     (flush),
        .cfg_en    (cfg_en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stall_cnt (stall_cnt)
    );

    // Reference model: each branch owns a queue of tokens it still has to see.
    // An accepted token is pushed onto the queue of every enabled branch;
    // a branch transfer pops its queue. A token is done when all queues drain.
    logic [W-1:0] exp_q [N][$];
    logic [W-1:0] m_data  = '0;   // value the broadcast register should show
    int           m_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, act, req);
        end
    endtask

    // Monitor: inputs are stable at the falling edge, so it evaluates the
    // outputs and advances the model to the state after the next rising edge.
    initial begin
        forever begin
            logic [N-1:0] m_vld;
            logic         m_rdy;
            logic         any_stall;
            @(negedge clk);
            cycle++;
            m_rdy     = 1'b1;
            any_stall = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_vld[i] = (exp_q[i].size() != 0);
                if (m_vld[i] && !out_ready[i]) begin
                    m_rdy     = 1'b0;
                    any_stall = 1'b1;
                end
            end
            check("in_ready",  {31'd0, in_ready}, {31'd0, m_rdy});
            check("out_valid", {26'd0, out_valid}, {26'd0, m_vld});
            check("out_data",  {15'd0, out_data}, {15'd0, m_data});
`ifdef FANOUT_STALL_CNT_EN
            check("stall_cnt", {16'd0, stall_cnt}, m_stall);
`else
            check("stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
            if (flush) begin
                for (int i = 0; i < N; i++) exp_q[i].delete();
                m_data  = '0;
                m_stall = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (m_vld[i] && out_ready[i]) void'(exp_q[i].pop_front());
                end
                if (any_stall && m_stall < 16'hFFFF) m_stall++;
                if (in_valid && m_rdy) begin
                    m_data = in_data;
                    for (int i = 0; i < N; i++) begin
                        if (cfg_en[i]) exp_q[i].push_back(in_data);
                    end
                end
            end
        end
    end

    task automatic step(input logic f, input logic [N-1:0] c, input logic v,
                        input logic [W-1:0] d, input logic [N-1:0] r);
        @(posedge clk);
        #2;
        flush     = f;
        cfg_en    = c;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic idle(input logic [N-1:0] c, input int n);
        for (int k = 0; k < n; k++) step(1'b0, c, 1'b0, '0, '1);
    endtask

    initial begin
        logic [N-1:0] rc;
        int           leftover;
        flush = 1'b1; cfg_en = '1; in_valid = 1'b0; in_data = '0; out_ready = '0;

        // Streaming on all branches.
        step(1'b1, 6'h3F, 1'b0, '0, '0);
        for (int k = 1; k <= 5; k++) step(1'b0, 6'h3F, 1'b1, 17'(k), 6'h3F);
        idle(6'h3F, 2);

        // Skewed readiness on three branches.
        step(1'b1, 6'h07, 1'b0, '0, '0);
        step(1'b0, 6'h07, 1'b1, 17'h0002A, 6'h00);
        step(1'b0, 6'h07, 1'b0, '0, 6'h01);
        step(1'b0, 6'h07, 1'b0, '0, 6'h01);
        step(1'b0, 6'h07, 1'b0, '0, 6'h02);
        step(1'b0, 6'h07, 1'b0, '0, 6'h00);
        step(1'b0, 6'h07, 1'b0, '0, 6'h04);
        idle(6'h07, 2);

        // Completion of A on the same edge that loads B.
        step(1'b1, 6'h03, 1'b0, '0, '0);
        step(1'b0, 6'h03, 1'b1, 17'h00A0A, 6'h00);
        step(1'b0, 6'h03, 1'b1, 17'h00B0B, 6'h01);
        step(1'b0, 6'h03, 1'b1, 17'h00B0B, 6'h02);
        step(1'b0, 6'h03, 1'b0, '0, 6'h03);
        idle(6'h03, 2);

        // All branches disabled: tokens are sunk.
        step(1'b1, 6'h00, 1'b0, '0, '0);
        for (int k = 0; k < 4; k++) step(1'b0, 6'h00, 1'b1, 17'(16'h100 + k), 6'($urandom));
        idle(6'h00, 2);

        // Control token between data tokens on branches 0 and 5.
        step(1'b1, 6'h21, 1'b0, '0, '0);
        step(1'b0, 6'h21, 1'b1, 17'h00011, 6'h21);
        step(1'b0, 6'h21, 1'b1, 17'h10000, 6'h21);
        step(1'b0, 6'h21, 1'b1, 17'h00012, 6'h21);
        idle(6'h21, 2);

        // Flush after branch 0 fired but branch 1 did not.
        step(1'b1, 6'h03, 1'b0, '0, '0);
        step(1'b0, 6'h03, 1'b1, 17'h00055, 6'h00);
        step(1'b0, 6'h03, 1'b0, '0, 6'h01);
        step(1'b1, 6'h03, 1'b0, '0, 6'h00);
        step(1'b0, 6'h03, 1'b1, 17'h00077, 6'h00);
        step(1'b0, 6'h03, 1'b0, '0, 6'h03);
        idle(6'h03, 2);

        // Randomized phases, each with its own enable mask and ready density.
        for (int p = 0; p < 8; p++) begin
            logic [N-1:0] c;
            int           rp;
            c  = (p == 0) ? 6'h00 : 6'($urandom);
            rp = 30 + 10 * p;
            step(1'b1, c, 1'b0, '0, '0);
            for (int k = 0; k < 250; k++) begin
                for (int i = 0; i < N; i++) rc[i] = ($urandom_range(99) < rp);
                step(($urandom_range(199) == 0), c, ($urandom_range(99) < 70),
                     17'($urandom), rc);
            end
            idle(c, 3);
        end

        @(negedge clk);
        #1;
        leftover = 0;
        for (int i = 0; i < N; i++) leftover += exp_q[i].size();
        check("drained", leftover, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_fanout_fork.md
Name: stream_fanout_fork

Overview:
- One-entry buffered eager fork.
- Accepts one ready/valid stream from a producing primitive (scanner, intersect, ALU) and broadcasts each token to up to NUM_OUT consumers.
- Tracks per-branch delivery, so each branch transfers independently. Upstream is released only when every enabled branch has taken the token.
- Sits directly upstream of the fanout ready-combine logic in the interconnect. Its in_ready is the registered-state counterpart of that all-branches-ready AND.

Parameters:
- NUM_OUT, 6, number of output branches.
- DATA_W, 17, token width: bit DATA_W-1 is the control/stop flag, the low bits are payload.

Ports:
- clk  input  1  clock.
- flush  input  1  synchronous active-high reset.
- cfg_en  input  NUM_OUT  static per-branch enable. Changes only while flush=1.
- in_data  input  DATA_W  upstream token.
- in_valid  input  1  upstream valid.
- in_ready  output  1  upstream ready.
- out_data  output  DATA_W  broadcast token, shared by all branches.
- out_valid  output  NUM_OUT  per-branch valid.
- out_ready  input  NUM_OUT  per-branch ready.
- stall_cnt  output  16  stall counter (see Optional Feature).

Behaviour:
- State: hold_data[DATA_W], hold_vld, sent[NUM_OUT].
- Reset (flush=1 at a clk edge): hold_vld=0, sent=0, hold_data=0, stall_cnt=0.
  - Outputs then read out_valid=0, out_data=0, in_ready=1.
  - Flush wins over every simultaneous event, and any in-flight token is discarded.
- out_data = hold_data.
- out_valid[i] = hold_vld & cfg_en[i] & ~sent[i].
- fire[i] = out_valid[i] & out_ready[i].
- done = hold_vld & AND over i of (~cfg_en[i] | sent[i] | out_ready[i]).
- in_ready = ~hold_vld | done. This path is combinational from out_ready. No combinational path from in_valid to any output.
- Next state, in priority order:
  - flush: reset as above.
  - in_valid & in_ready: hold_data=in_data, hold_vld=1, sent=0. This covers a simultaneous completion and new load.
  - done with no new input: hold_vld=0, sent=0.
  - otherwise: sent |= fire.
- Latency: token accepted at edge N appears on out_valid after edge N (1 cycle).
- Throughput: 1 token/cycle when all enabled branches are ready.
- Each branch sees each token exactly once. A branch that has already fired keeps out_valid low until the next token, even if it stays ready.
- A branch with cfg_en=0 never asserts out_valid and never blocks.
- If cfg_en is all zero, done = hold_vld, so tokens are sunk with 1-cycle occupancy and in_ready stays 1.
- Control tokens (bit DATA_W-1 = 1) are handled identically to data tokens: no reordering, no dropping.
- Data is held stable while hold_vld=1 and the token is not complete.

Optional Feature:
- Macro: FANOUT_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on each cycle where hold_vld=1 and done=0.
  - It saturates at 16'hFFFF and clears only on flush.
  - It counts cycles where some enabled branch withholds ready.
- Undefined:
  - stall_cnt is tied to 0 and no counter flops are synthesized.
  - All other behaviour is identical.

Test Plan:
- Streaming, cfg_en=6'b111111, all out_ready=1, in_valid=1 with tokens 0x00001..0x00005:
  - one token per cycle on all six branches;
  - in_ready constantly 1;
  - stall_cnt=0.
- Skewed readiness, cfg_en=6'b000111, token 0x0002A:
  - out_ready[0] at cycle 1, [1] at cycle 3, [2] at cycle 5;
  - each branch fires once; out_valid[0] drops after cycle 1;
  - in_ready=1 only in cycle 5;
  - with the macro, stall_cnt=4.
- Completion with back-to-back load, token A then B in consecutive cycles:
  - last branch becomes ready while B is valid;
  - B is loaded in the same edge that A completes, and sent clears;
  - no bubble, and no branch sees A twice.
- Disabled branches, cfg_en=0:
  - in_valid=1 for 4 tokens;
  - out_valid stays 0;
  - in_ready=1 every cycle and all tokens are sunk.
- Control token 0x10000 with cfg_en=6'b100001:
  - delivered unchanged on branches 0 and 5 only, in order after preceding data tokens.
- Flush mid-token, after branch 0 has fired but branch 1 has not:
  - flush=1 for 1 cycle gives out_valid=0 and in_ready=1 next cycle;
  - the next token is delivered to both branches.
